im_port_arbiter: RTL and testbench

// - Shares the single port of the instruction memory between two requesters: CPU fetch (F) and
//   the debug/loader port (D).
// - D may write instructions (program load) or read them back. D may also lock the memory for
//   a burst load, during which F stalls.
// - Sits between the PC/fetch stage, the debug loader and a synchronous 1-cycle-latency IM array.

---
 rtl/im_pkg.sv | 23 ++
 rtl/im_starve_ctr.sv | 33 +++
 rtl/im_port_arbiter.sv | 121 ++++++++++++
 tb/tb_im_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/im_pkg.sv
// Shared types and widths for the instruction-memory port arbiter.
//   IM_ADDR_W   : word-address width of the IM port (byte address bits [11:2])
//   IM_DATA_W   : instruction word width
//   arb_state_t : arbiter ownership state (open arbitration, debug lock, drain)
//   resp_sel_t  : which requester owns the read response due next cycle
package im_pkg;

    localparam int IM_ADDR_W = 10;
    localparam int IM_DATA_W = 32;

    typedef enum logic [1:0] {
        ARB,
        LOCK,
        DRAIN
    } arb_state_t;

    typedef enum logic [1:0] {
        NONE,
        F,
        D
    } resp_sel_t;

endpackage

// File: rtl/im_starve_ctr.sv
// Saturating counter with synchronous clear; counts refused debug cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one more refusal (ignored once saturated)
//   clr        : clear to zero (wins over inc)
//   sat        : counter has reached MAX
module im_starve_ctr #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int unsigned W = $clog2(MAX + 1);

    logic [W-1:0] count;

    assign sat = (count == W'(MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/im_port_arbiter.sv
// Shares the single instruction-memory port between CPU fetch (F) and the
// debug/loader port (D). F normally wins; D wins when F is idle or after
// STARVE_MAX consecutive refusals. D may lock the port for a burst load,
// followed by one drain cycle before fetch resumes.
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   f_req/f_addr -> f_gnt             : fetch read request and acceptance
//   f_rvalid/f_rdata                  : fetch read response (1 cycle after f_gnt)
//   d_req/d_we/d_lock/d_addr/d_wdata  : debug request (read/write, lock)
//   d_gnt, d_rvalid/d_rdata           : debug acceptance and read response
//   locked                            : port currently owned by D
//   mem_en/mem_we/mem_addr/mem_wdata  : IM port command
//   mem_rdata                         : IM registered read data
module im_port_arbiter
    import im_pkg::*;
#(
    parameter int          ADDR_W     = IM_ADDR_W,
    parameter int          DATA_W     = IM_DATA_W,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_lock,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              locked,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state, state_next;
    resp_sel_t  resp_sel;
    logic       d_starved;

    im_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (d_req && !d_gnt),
        .clr   (d_gnt),
        .sat   (d_starved)
    );

    always_comb begin
        f_gnt      = 1'b0;
        d_gnt      = 1'b0;
        state_next = state;
        case (state)
            ARB: begin
                if (d_req && (!f_req || d_starved)) begin
                    d_gnt = 1'b1;
                end else begin
                    f_gnt = f_req;
                end
                if (d_gnt && d_lock) begin
                    state_next = LOCK;
                end
            end
            LOCK: begin
                d_gnt = d_req;
                if (!d_lock) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                state_next = ARB;
            end
            default: begin
                state_next = ARB;
            end
        endcase
        // Grants are combinational, so they are also held off while reset is asserted.
        if (!rst_n) begin
            f_gnt = 1'b0;
            d_gnt = 1'b0;
        end
    end

    assign mem_en    = f_gnt || d_gnt;
    assign mem_we    = d_gnt && d_we;
    assign mem_addr  = d_gnt ? d_addr : f_addr;
    assign mem_wdata = d_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            locked   <= 1'b0;
            resp_sel <= NONE;
        end else begin
            state    <= state_next;
            locked   <= (state_next == LOCK);
            if (f_gnt) begin
                resp_sel <= F;
            end else if (d_gnt && !d_we) begin
                resp_sel <= D;
            end else begin
                resp_sel <= NONE;
            end
        end
    end

    assign f_rvalid = (resp_sel == F);
    assign d_rvalid = (resp_sel == D);
    assign f_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule

// File: tb/tb_im_port_arbiter.sv
module tb_im_port_arbiter;

    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f_req;
    logic [9:0]  f_addr;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic        d_lock;
    logic [9:0]  d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        locked;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    im_port_arbiter #(
        .ADDR_W     (10),
        .DATA_W     (32),
        .STARVE_MAX (STARVE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_lock    (d_lock),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .locked    (locked),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port IM array, 1-cycle read latency.
    logic [31:0] im_array [1024];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) im_array[mem_addr] <= mem_wdata;
            else        mem_rdata <= im_array[mem_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model: ownership phase (0 open, 1 owned by D, 2 settling),
    // consecutive D refusals, and a shadow of the memory contents.
    int          phase;
    int          refused;
    logic [31:0] shadow [1024];

    // Model-predicted grants (drive stimulus) and observed values (directed checks).
    bit          exp_f_gnt, exp_d_gnt;
    logic        obs_f_gnt, obs_d_gnt;
    logic [31:0] obs_f_rdata, obs_d_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        phase   = 0;
        refused = 0;
    endtask

    // One clock cycle: inputs already driven at negedge.
    task automatic tick();
        bit          ef, ed, exp_frv, exp_drv;
        logic [31:0] exp_word;
        #1;
        if (phase == 0) begin
            ed = d_req && (!f_req || refused >= STARVE);
            ef = f_req && !ed;
        end else if (phase == 1) begin
            ed = d_req;
            ef = 1'b0;
        end else begin
            ed = 1'b0;
            ef = 1'b0;
        end
        exp_f_gnt = ef;
        exp_d_gnt = ed;
        obs_f_gnt = f_gnt;
        obs_d_gnt = d_gnt;
        check("f_gnt", {31'b0, f_gnt}, {31'b0, ef});
        check("d_gnt", {31'b0, d_gnt}, {31'b0, ed});
        check("mem_en", {31'b0, mem_en}, {31'b0, ef | ed});
        check("mem_we", {31'b0, mem_we}, {31'b0, ed & d_we});
        if (ef) check("mem_addr_f", {22'b0, mem_addr}, {22'b0, f_addr});
        if (ed) check("mem_addr_d", {22'b0, mem_addr}, {22'b0, d_addr});
        if (ed && d_we) check("mem_wdata", mem_wdata, d_wdata);

        exp_frv  = ef;
        exp_drv  = ed && !d_we;
        exp_word = ef ? shadow[f_addr] : shadow[d_addr];
        if (ed && d_we) shadow[d_addr] = d_wdata;

        if (ed) refused = 0;
        else if (d_req) refused++;
        case (phase)
            0: if (ed && d_lock) phase = 1;
            1: if (!d_lock) phase = 2;
            default: phase = 0;
        endcase

        @(posedge clk);
        @(negedge clk);
        obs_f_rdata = f_rdata;
        obs_d_rdata = d_rdata;
        check("f_rvalid", {31'b0, f_rvalid}, {31'b0, exp_frv});
        check("d_rvalid", {31'b0, d_rvalid}, {31'b0, exp_drv});
        if (exp_frv) check("f_rdata", f_rdata, exp_word);
        if (exp_drv) check("d_rdata", d_rdata, exp_word);
        check("locked", {31'b0, locked}, {31'b0, phase == 1});
    endtask

    task automatic d_write(input logic [9:0] a, input logic [31:0] w);
        d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = w;
        tick();
        d_req = 1'b0; d_we = 1'b0;
    endtask

    int          gnt_cycle;
    bit          f_after;
    logic [31:0] wr_word;

    initial begin
        rst_n = 1'b0;
        f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_lock = 1'b0; d_addr = '0; d_wdata = '0;
        model_reset();
        foreach (shadow[i]) shadow[i] = 32'hx;

        // Reset state
        #2;
        check("rst_f_rvalid", {31'b0, f_rvalid}, 32'd0);
        check("rst_d_rvalid", {31'b0, d_rvalid}, 32'd0);
        check("rst_locked", {31'b0, locked}, 32'd0);
        check("rst_mem_en", {31'b0, mem_en}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Preload program and data through the debug port
        d_write(10'h000, 32'h20080005);
        d_write(10'h001, 32'h20090003);
        d_write(10'h002, 32'h01095020);
        for (int unsigned i = 3; i < 16; i++) d_write(10'(i), $urandom);
        d_write(10'h010, 32'hCAFEF00D);

        // Fetch only: back-to-back reads
        f_req = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            f_addr = 10'(i);
            tick();
        end
        f_req = 1'b0;
        tick();
        check("fetch_last_word", obs_f_rdata, 32'h01095020);

        // Starvation: both requesting continuously
        f_req = 1'b1; f_addr = 10'h003;
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h004;
        gnt_cycle = 0;
        f_after = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (obs_d_gnt === 1'b1 && gnt_cycle == 0) gnt_cycle = c;
            if (c == 6) f_after = (obs_f_gnt === 1'b1);
            if (exp_d_gnt) d_req = 1'b0;
        end
        check("starve_gnt_cycle", 32'(gnt_cycle), 32'd5);
        check("starve_f_regains", {31'b0, f_after}, 32'd1);
        f_req = 1'b0;
        tick();

        // Burst load under lock
        d_lock = 1'b1;
        d_write(10'h3FF, 32'hDEADBEEF);
        f_req = 1'b1; f_addr = 10'h3FF;
        d_write(10'h000, 32'h00000000);
        tick();
        check("burst_locked", {31'b0, locked}, 32'd1);
        d_lock = 1'b0;
        tick();
        tick();
        check("drain_no_fgnt", {31'b0, obs_f_gnt}, 32'd0);
        tick();
        check("post_drain_fgnt", {31'b0, obs_f_gnt}, 32'd1);
        f_req = 1'b0;
        tick();
        check("post_load_fetch", obs_f_rdata, 32'hDEADBEEF);

        // Readback with F idle
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h010;
        tick();
        check("readback_same_cycle_gnt", {31'b0, obs_d_gnt}, 32'd1);
        d_req = 1'b0;
        tick();
        check("readback_word", obs_d_rdata, 32'hCAFEF00D);

        // Write then read the same address on consecutive grants
        wr_word = $urandom;
        d_write(10'h020, wr_word);
        d_req = 1'b1; d_we = 1'b0; d_addr = 10'h020;
        tick();
        d_req = 1'b0;
        tick();
        check("write_then_read", obs_d_rdata, wr_word);

        // Reset asserted while a fetch response is due
        f_req = 1'b1; f_addr = 10'h001;
        #1;
        @(posedge clk);
        #1;
        check("pre_reset_f_rvalid", {31'b0, f_rvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_f_rvalid", {31'b0, f_rvalid}, 32'd0);
        check("mid_reset_f_gnt", {31'b0, f_gnt}, 32'd0);
        check("mid_reset_mem_en", {31'b0, mem_en}, 32'd0);
        check("mid_reset_locked", {31'b0, locked}, 32'd0);
        @(negedge clk);
        f_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        tick();

        // Randomized traffic; requesters hold their request until granted
        for (int n = 0; n < 400; n++) begin
            if (!f_req || exp_f_gnt) begin
                f_req  = ($urandom_range(0, 9) < 6);
                f_addr = 10'($urandom_range(0, 15));
            end
            if (!d_req || exp_d_gnt) begin
                d_req   = ($urandom_range(0, 2) == 0);
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 10'($urandom_range(0, 15));
                d_wdata = $urandom;
            end
            if ($urandom_range(0, 7) == 0) d_lock = !d_lock;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
